// File: rtl/par_traffic_gen_if.sv
// par_traffic_gen_if
//   Flit transfer channel between a traffic source and its downstream sink.
//   FW      : flit width (HDR_SZ + PL_SZ + ADDR_SZ of the connected source)
//   data    : flit {hdr, payload, dest}, dest in the low bits
//   valid   : data holds a flit waiting to transfer
//   busy    : sink cannot accept this cycle
//   master  : the flit source (drives data/valid, samples busy)
//   slave   : the flit sink   (samples data/valid, drives busy)
interface par_traffic_gen_if #(
  parameter int FW = 22
) ();
  logic [FW-1:0] data;
  logic          valid;
  logic          busy;

  modport master (output data, output valid, input busy);
  modport slave  (input data, input valid, output busy);
endinterface

// File: rtl/par_traffic_gen.sv
// par_traffic_gen
//   Synthetic packet source for network-on-chip traffic. Generates one-flit
//   packets at a programmable injection rate, with uniform-random,
//   round-robin or hotspot destination selection, driven by a 16-bit LFSR.
// Ports
//   clk         : single clock, rising-edge active
//   reset       : asynchronous, active-high
//   tx          : flit channel (data/valid out, busy in)
//   send        : global enable for flit generation and LFSR advance
//   done        : MAX_PKTS flits have been accepted (sticky until reset)
//   sent_count  : accepted flits, saturating at 20'hFFFFF
//   stall_count : cycles with valid=1 and busy=1, saturating at 20'hFFFFF
module par_traffic_gen #(
  parameter int          ID       = 0,
  parameter int          DESTS    = 9,
  parameter int          PIR      = 255,
  parameter int          MODE     = 0,
  parameter int          HOTSPOT  = 0,
  parameter int          MAX_PKTS = 0,
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int          HDR_SZ   = 2,
  parameter int          PL_SZ    = 16,
  parameter int          ADDR_SZ  = 4
) (
  input  logic              clk,
  input  logic              reset,
  par_traffic_gen_if.master tx,
  input  logic              send,
  output logic              done,
  output logic [19:0]       sent_count,
  output logic [19:0]       stall_count
);

  localparam int FW = HDR_SZ + PL_SZ + ADDR_SZ;

  localparam logic [15:0]        SEED_MIX  = SEED ^ 16'(ID);
  localparam logic [15:0]        LFSR_INIT = (SEED_MIX == 16'd0) ? 16'hACE1 : SEED_MIX;
  localparam logic [ADDR_SZ-1:0] ID_A      = ADDR_SZ'(ID);
  localparam logic [ADDR_SZ-1:0] NEXT_A    = ADDR_SZ'((ID + 1) % DESTS);
  localparam logic [ADDR_SZ-1:0] LAST_A    = ADDR_SZ'(DESTS - 1);
  localparam logic [ADDR_SZ-1:0] HOT_A     = ADDR_SZ'(HOTSPOT);
  localparam logic [HDR_SZ-1:0]  HDR_V     = HDR_SZ'(ID);
  localparam logic [19:0]        CNT_MAX   = 20'hFFFFF;
  localparam logic [19:0]        MAX_LIM   = 20'(MAX_PKTS);
  localparam bit                 LIMITED   = (MAX_PKTS > 0);
  localparam bit                 HOT_EN    = (MODE == 2) && (HOTSPOT != ID);
  // Never zero, so the rate compare below is never trivially false; PIR=0
  // is excluded explicitly instead.
  localparam logic [7:0]         PIR_B     = (PIR <= 0) ? 8'd1 : 8'(PIR);

  logic [15:0]        lfsr_q,  lfsr_d;
  logic [FW-1:0]      data_q,  data_d;
  logic               valid_q, valid_d;
  logic [PL_SZ-1:0]   seq_q,   seq_d;
  logic [ADDR_SZ-1:0] rr_q,    rr_d;
  logic [19:0]        inj_q,   inj_d;
  logic               done_q,  done_d;
  logic [19:0]        sent_q,  sent_d;
  logic [19:0]        stall_q, stall_d;

  logic               lfsr_fb;
  logic               xfer, stall, slot_free, limit_ok, rate_hit, inject;
  logic [ADDR_SZ-1:0] rnd_raw, rnd_dest, rr_inc, rr_next, dest;

  // Fibonacci form shifting right: taps 16,14,13,11 land on bits 0,2,3,5.
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  assign xfer      = valid_q & ~tx.busy;
  assign stall     = valid_q &  tx.busy;
  assign slot_free = ~valid_q | xfer;

  // Injections are capped at MAX_PKTS so no extra flit is launched on the
  // edge that accepts the last one (done is only visible after that edge).
  assign limit_ok = !LIMITED || (inj_q != MAX_LIM);

  assign rate_hit = (PIR >= 255) || ((PIR > 0) && (lfsr_q[7:0] < PIR_B));
  assign inject   = send & slot_free & ~done_q & limit_ok & rate_hit;

  assign rnd_raw  = ADDR_SZ'({1'b0, lfsr_q[15:8]} % 9'(DESTS));
  assign rnd_dest = (rnd_raw == ID_A) ? NEXT_A : rnd_raw;

  // Round-robin successor, stepping over this node's own index.
  assign rr_inc  = (rr_q == LAST_A) ? '0 : rr_q + ADDR_SZ'(1);
  assign rr_next = (rr_inc != ID_A) ? rr_inc :
                   (rr_inc == LAST_A) ? '0 : rr_inc + ADDR_SZ'(1);

  always_comb begin
    if (DESTS == 1) begin
      dest = ID_A;
    end else if (MODE == 1) begin
      dest = rr_q;
    end else if (HOT_EN && !seq_q[0]) begin
      // seq_q counts prior injections, so even seq_q means an odd injection.
      dest = HOT_A;
    end else begin
      dest = rnd_dest;
    end
  end

  always_comb begin
    lfsr_d  = lfsr_q;
    data_d  = data_q;
    valid_d = valid_q;
    seq_d   = seq_q;
    rr_d    = rr_q;
    inj_d   = inj_q;
    done_d  = done_q;
    sent_d  = sent_q;
    stall_d = stall_q;

    if (send) begin
      lfsr_d = {lfsr_fb, lfsr_q[15:1]};
    end

    if (inject) begin
      data_d  = {HDR_V, seq_q, dest};
      valid_d = 1'b1;
      seq_d   = seq_q + PL_SZ'(1);
      rr_d    = rr_next;
      inj_d   = inj_q + 20'd1;
    end else if (slot_free) begin
      valid_d = 1'b0;
    end

    if (xfer && (sent_q != CNT_MAX)) begin
      sent_d = sent_q + 20'd1;
    end
    if (stall && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + 20'd1;
    end

    if (LIMITED && xfer && ((sent_q + 20'd1) == MAX_LIM)) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q  <= LFSR_INIT;
      data_q  <= '0;
      valid_q <= 1'b0;
      seq_q   <= '0;
      rr_q    <= NEXT_A;
      inj_q   <= '0;
      done_q  <= 1'b0;
      sent_q  <= '0;
      stall_q <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      seq_q   <= seq_d;
      rr_q    <= rr_d;
      inj_q   <= inj_d;
      done_q  <= done_d;
      sent_q  <= sent_d;
      stall_q <= stall_d;
    end
  end

  assign tx.data     = data_q;
  assign tx.valid    = valid_q;
  assign done        = done_q;
  assign sent_count  = sent_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_par_traffic_gen.sv
// tb_par_traffic_gen
//   Bench for par_traffic_gen. Several differently parameterised sources
//   share clock, reset and send; each has its own channel so busy can be
//   driven per source. Expected flits come from a behavioural model of the
//   destination/payload rules and an LFSR stepped in plain arithmetic.
module tb_par_traffic_gen;
  localparam int FW = 22;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic send  = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  par_traffic_gen_if #(.FW(FW)) if_rr  ();
  par_traffic_gen_if #(.FW(FW)) if_lim ();
  par_traffic_gen_if #(.FW(FW)) if_p0  ();
  par_traffic_gen_if #(.FW(FW)) if_rnd ();
  par_traffic_gen_if #(.FW(FW)) if_hs0 ();
  par_traffic_gen_if #(.FW(FW)) if_hs4 ();
  par_traffic_gen_if #(.FW(FW)) if_d1  ();

  logic        done_rr, done_lim, done_p0, done_rnd, done_hs0, done_hs4, done_d1;
  logic [19:0] sent_rr, sent_lim, sent_p0, sent_rnd, sent_hs0, sent_hs4, sent_d1;
  logic [19:0] stall_rr, stall_lim, stall_p0, stall_rnd, stall_hs0, stall_hs4, stall_d1;

  par_traffic_gen #(.ID(0), .DESTS(9), .PIR(255), .MODE(1)) u_rr (
    .clk(clk), .reset(reset), .tx(if_rr), .send(send),
    .done(done_rr), .sent_count(sent_rr), .stall_count(stall_rr));
  par_traffic_gen #(.ID(0), .DESTS(9), .PIR(255), .MODE(1), .MAX_PKTS(3)) u_lim (
    .clk(clk), .reset(reset), .tx(if_lim), .send(send),
    .done(done_lim), .sent_count(sent_lim), .stall_count(stall_lim));
  par_traffic_gen #(.ID(0), .DESTS(9), .PIR(0), .MODE(0)) u_p0 (
    .clk(clk), .reset(reset), .tx(if_p0), .send(send),
    .done(done_p0), .sent_count(sent_p0), .stall_count(stall_p0));
  par_traffic_gen #(.ID(3), .DESTS(9), .PIR(128), .MODE(0)) u_rnd (
    .clk(clk), .reset(reset), .tx(if_rnd), .send(send),
    .done(done_rnd), .sent_count(sent_rnd), .stall_count(stall_rnd));
  par_traffic_gen #(.ID(0), .DESTS(9), .PIR(255), .MODE(2), .HOTSPOT(4)) u_hs0 (
    .clk(clk), .reset(reset), .tx(if_hs0), .send(send),
    .done(done_hs0), .sent_count(sent_hs0), .stall_count(stall_hs0));
  par_traffic_gen #(.ID(4), .DESTS(9), .PIR(255), .MODE(2), .HOTSPOT(4)) u_hs4 (
    .clk(clk), .reset(reset), .tx(if_hs4), .send(send),
    .done(done_hs4), .sent_count(sent_hs4), .stall_count(stall_hs4));
  par_traffic_gen #(.ID(0), .DESTS(1), .PIR(255), .MODE(0)) u_d1 (
    .clk(clk), .reset(reset), .tx(if_d1), .send(send),
    .done(done_d1), .sent_count(sent_d1), .stall_count(stall_d1));

  // ---------------- reference model pieces ----------------
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic b;
    b = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {b, s[15:1]};
  endfunction

  function automatic logic [15:0] lfsr_init(input int id);
    logic [15:0] v;
    v = 16'hACE1 ^ 16'(id);
    return (v == 16'd0) ? 16'hACE1 : v;
  endfunction

  function automatic int rand_dest(input logic [15:0] s, input int id, input int dests);
    int d;
    d = int'(s[15:8]) % dests;
    if (d == id) d = (id + 1) % dests;
    return d;
  endfunction

  function automatic logic [FW-1:0] mk_flit(input int id, input int pay, input int dest);
    return {2'(id), 16'(pay), 4'(dest)};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_busy();
    if_rr.busy = 1'b0;  if_lim.busy = 1'b0; if_p0.busy = 1'b0; if_rnd.busy = 1'b0;
    if_hs0.busy = 1'b0; if_hs4.busy = 1'b0; if_d1.busy = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    send  = 1'b0;
    clear_busy();
    step();
    step();
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    send  = 1'b0;
    clear_busy();
    step();
    checks++; if (if_rr.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", if_rr.valid); end
    checks++; if (if_rr.data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", if_rr.data); end
    checks++; if (done_lim !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_lim); end
    checks++; if (sent_rr !== 20'd0) begin errors++; $display("FAIL reset_sent got %0d want 0", sent_rr); end
    checks++; if (stall_rr !== 20'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", stall_rr); end
    send = 1'b1;
    step();
    checks++; if (if_hs0.valid !== 1'b0) begin errors++; $display("FAIL reset_hold_valid got %b want 0", if_hs0.valid); end
    send = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [FW-1:0] exp;
    do_reset();
    send = 1'b1;
    for (int k = 0; k < 18; k++) begin
      step();
      exp = mk_flit(0, k, 1 + (k % 8));
      checks++;
      if (if_rr.valid !== 1'b1 || if_rr.data !== exp) begin
        errors++; $display("FAIL rr_flit%0d got v=%b %h want v=1 %h", k, if_rr.valid, if_rr.data, exp);
      end
      checks++;
      if (sent_rr !== 20'(k)) begin errors++; $display("FAIL rr_sent%0d got %0d want %0d", k, sent_rr, k); end
    end
  endtask

  task automatic test_stall_and_send();
    logic [FW-1:0] exp;
    int mk, msent, mstall;
    logic b;
    do_reset();
    send = 1'b1;
    step();
    step();
    if_rr.busy = 1'b1;
    exp = mk_flit(0, 1, 2);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (if_rr.valid !== 1'b1 || if_rr.data !== exp) begin
        errors++; $display("FAIL stall_hold%0d got v=%b %h want v=1 %h", i, if_rr.valid, if_rr.data, exp);
      end
    end
    checks++; if (stall_rr !== 20'd5) begin errors++; $display("FAIL stall_count got %0d want 5", stall_rr); end
    if_rr.busy = 1'b0;
    step();
    checks++; if (sent_rr !== 20'd2) begin errors++; $display("FAIL stall_release_sent got %0d want 2", sent_rr); end
    checks++;
    if (if_rr.data !== mk_flit(0, 2, 3)) begin
      errors++; $display("FAIL stall_release_flit got %h want %h", if_rr.data, mk_flit(0, 2, 3));
    end

    // Pending flit survives send=0, then the slot empties and stays empty.
    if_rr.busy = 1'b1;
    send = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (if_rr.valid !== 1'b1 || if_rr.data !== mk_flit(0, 2, 3)) begin
        errors++; $display("FAIL nosend_hold%0d got v=%b %h want v=1 %h", i, if_rr.valid, if_rr.data, mk_flit(0, 2, 3));
      end
    end
    if_rr.busy = 1'b0;
    step();
    checks++; if (if_rr.valid !== 1'b0) begin errors++; $display("FAIL nosend_drain got %b want 0", if_rr.valid); end
    step();
    checks++; if (if_rr.valid !== 1'b0) begin errors++; $display("FAIL nosend_idle got %b want 0", if_rr.valid); end
    checks++; if (sent_rr !== 20'd3) begin errors++; $display("FAIL nosend_sent got %0d want 3", sent_rr); end
    send = 1'b1;
    step();
    checks++;
    if (if_rr.valid !== 1'b1 || if_rr.data !== mk_flit(0, 3, 4)) begin
      errors++; $display("FAIL resume_flit got v=%b %h want v=1 %h", if_rr.valid, if_rr.data, mk_flit(0, 3, 4));
    end

    // Random backpressure against a flit-order scoreboard.
    mk = 3; msent = 3; mstall = 9;
    for (int i = 0; i < 400; i++) begin
      b = ($urandom_range(0, 2) == 0);
      if_rr.busy = b;
      if (b) mstall++;
      else begin msent++; mk++; end
      step();
      exp = mk_flit(0, mk, 1 + (mk % 8));
      checks++;
      if (if_rr.valid !== 1'b1 || if_rr.data !== exp) begin
        errors++; $display("FAIL bp_flit%0d got v=%b %h want v=1 %h", i, if_rr.valid, if_rr.data, exp);
      end
      checks++;
      if (sent_rr !== 20'(msent) || stall_rr !== 20'(mstall)) begin
        errors++; $display("FAIL bp_counts%0d got %0d/%0d want %0d/%0d", i, sent_rr, stall_rr, msent, mstall);
      end
    end
    if_rr.busy = 1'b0;
  endtask

  task automatic test_max_pkts();
    logic ev, ed;
    int es;
    do_reset();
    send = 1'b1;
    for (int e = 1; e <= 34; e++) begin
      if (e >= 5) if_lim.busy = ($urandom_range(0, 1) == 1);
      step();
      ev = (e <= 3);
      ed = (e >= 4);
      es = (e - 1 > 3) ? 3 : e - 1;
      checks++;
      if (if_lim.valid !== ev || done_lim !== ed || sent_lim !== 20'(es)) begin
        errors++; $display("FAIL max_edge%0d got v=%b d=%b s=%0d want v=%b d=%b s=%0d",
                           e, if_lim.valid, done_lim, sent_lim, ev, ed, es);
      end
    end
    checks++; if (stall_lim !== 20'd0) begin errors++; $display("FAIL max_stall got %0d want 0", stall_lim); end
    if_lim.busy = 1'b0;
  endtask

  task automatic test_pir_zero();
    int seen;
    do_reset();
    send = 1'b1;
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      if_p0.busy = ($urandom_range(0, 3) == 0);
      step();
      if (if_p0.valid !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL pir0_valid_cycles got %0d want 0", seen); end
    checks++; if (sent_p0 !== 20'd0) begin errors++; $display("FAIL pir0_sent got %0d want 0", sent_p0); end
    if_p0.busy = 1'b0;
  endtask

  task automatic test_random_mode0();
    logic [15:0] ml;
    logic mv, b, xf;
    logic [FW-1:0] md;
    int seq, msent, mstall, dut_inj, idhit;
    do_reset();
    send = 1'b1;
    ml = lfsr_init(3); mv = 1'b0; md = '0;
    seq = 0; msent = 0; mstall = 0; dut_inj = 0; idhit = 0;
    for (int c = 0; c < 12000; c++) begin
      b = (c >= 10000) ? ($urandom_range(0, 1) == 1) : 1'b0;
      if_rnd.busy = b;
      xf = mv && !b;
      if (xf) msent++;
      if (mv && b) mstall++;
      if (!mv || xf) begin
        if (ml[7:0] < 8'd128) begin
          mv = 1'b1;
          md = mk_flit(3, seq, rand_dest(ml, 3, 9));
          seq++;
        end else begin
          mv = 1'b0;
        end
      end
      ml = lfsr_next(ml);
      step();
      checks++;
      if (if_rnd.valid !== mv || (mv && if_rnd.data !== md)) begin
        errors++; $display("FAIL rnd_flit%0d got v=%b %h want v=%b %h", c, if_rnd.valid, if_rnd.data, mv, md);
      end
      if (c < 10000 && if_rnd.valid === 1'b1) dut_inj++;
      if (if_rnd.valid === 1'b1 && if_rnd.data[3:0] == 4'd3) idhit++;
    end
    checks++;
    if (dut_inj < 4700 || dut_inj > 5300) begin
      errors++; $display("FAIL rnd_ratio got %0d/10000 want 4700..5300", dut_inj);
    end
    checks++; if (idhit !== 0) begin errors++; $display("FAIL rnd_dest_is_id got %0d want 0", idhit); end
    checks++;
    if (sent_rnd !== 20'(msent) || stall_rnd !== 20'(mstall)) begin
      errors++; $display("FAIL rnd_counts got %0d/%0d want %0d/%0d", sent_rnd, stall_rnd, msent, mstall);
    end
    if_rnd.busy = 1'b0;
  endtask

  task automatic test_hotspot_and_single();
    logic [15:0] l0, l4;
    logic [FW-1:0] e0, e4, e1;
    int hit4;
    do_reset();
    send = 1'b1;
    l0 = lfsr_init(0);
    l4 = lfsr_init(4);
    hit4 = 0;
    for (int n = 1; n <= 200; n++) begin
      e0 = mk_flit(0, n - 1, (n % 2 == 1) ? 4 : rand_dest(l0, 0, 9));
      e4 = mk_flit(4, n - 1, rand_dest(l4, 4, 9));
      e1 = mk_flit(0, n - 1, 0);
      l0 = lfsr_next(l0);
      l4 = lfsr_next(l4);
      step();
      checks++;
      if (if_hs0.valid !== 1'b1 || if_hs0.data !== e0) begin
        errors++; $display("FAIL hs0_flit%0d got v=%b %h want v=1 %h", n, if_hs0.valid, if_hs0.data, e0);
      end
      checks++;
      if (if_hs4.valid !== 1'b1 || if_hs4.data !== e4) begin
        errors++; $display("FAIL hs4_flit%0d got v=%b %h want v=1 %h", n, if_hs4.valid, if_hs4.data, e4);
      end
      checks++;
      if (if_d1.valid !== 1'b1 || if_d1.data !== e1) begin
        errors++; $display("FAIL d1_flit%0d got v=%b %h want v=1 %h", n, if_d1.valid, if_d1.data, e1);
      end
      if (if_hs4.data[3:0] == 4'd4) hit4++;
    end
    checks++; if (hit4 !== 0) begin errors++; $display("FAIL hs4_dest_is_id got %0d want 0", hit4); end
  endtask

  task automatic test_async_reset();
    logic [15:0] ml;
    logic mv;
    logic [FW-1:0] md;
    int seq;
    do_reset();
    send = 1'b1;
    repeat (6) step();
    checks++; if (if_rr.valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid got %b want 1", if_rr.valid); end
    #3;
    reset = 1'b1;
    #1;
    checks++; if (if_rr.valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b want 0", if_rr.valid); end
    checks++; if (if_rr.data !== '0) begin errors++; $display("FAIL areset_data got %h want 0", if_rr.data); end
    checks++; if (sent_rr !== 20'd0) begin errors++; $display("FAIL areset_sent got %0d want 0", sent_rr); end
    step();
    reset = 1'b0;
    ml = lfsr_init(3); seq = 0;
    for (int c = 0; c < 40; c++) begin
      mv = (ml[7:0] < 8'd128);
      md = mv ? mk_flit(3, seq, rand_dest(ml, 3, 9)) : '0;
      if (mv) seq++;
      ml = lfsr_next(ml);
      step();
      if (c == 0) begin
        checks++;
        if (if_rr.valid !== 1'b1 || if_rr.data !== mk_flit(0, 0, 1)) begin
          errors++; $display("FAIL areset_first_flit got v=%b %h want v=1 %h", if_rr.valid, if_rr.data, mk_flit(0, 0, 1));
        end
      end
      checks++;
      if (if_rnd.valid !== mv || (mv && if_rnd.data !== md)) begin
        errors++; $display("FAIL areset_rnd%0d got v=%b %h want v=%b %h", c, if_rnd.valid, if_rnd.data, mv, md);
      end
    end
  endtask

  initial begin
    clear_busy();
    test_reset();
    test_round_robin();
    test_stall_and_send();
    test_max_pkts();
    test_pir_zero();
    test_random_mode0();
    test_hotspot_and_single();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
